hilo_unit: RTL

Owner of the architectural HI/LO register pair and the multi-cycle multiply/divide datapath. It sits in the execute stage and consumes the per-instruction HI/LO write requests that decode produces for MTHI, MTLO, MULT, MULTU, DIV and DIVU. It commits results into HI/LO and exposes them for MFHI/MFLO. It raises `busy` so the pipeline stalls while a multiply or divide is in flight.

---
 rtl/hilo_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with a multi-cycle multiplier and a
// restoring radix-2 divider; busy stalls the pipeline while either is in flight.
module hilo_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_vs,
    input  logic [31:0] req_vt,
    output logic        req_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MTHI  = 3'd1;
    localparam logic [2:0] OP_MTLO  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_DIVU  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dzero_q, dzero_d;

    logic        op_valid;
    logic        accept;
    logic        req_signed;
    logic [63:0] a_ext, b_ext, product;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        rem_ge;
    logic [31:0] q_fix, r_fix;

    assign op_valid  = (req_op >= OP_MTHI) && (req_op <= OP_DIVU);
    assign req_ready = !reset && !flush && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready && op_valid;
    assign req_signed = (req_op == OP_MULT) || (req_op == OP_DIV);

    // Sign- or zero-extend to 64 bits so one multiplier serves both ops.
    assign a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = a_ext * b_ext;

    // One restoring step: the modular 32-bit difference is exact whenever it is kept.
    assign rem_sh  = {rem_q, quot_q[31]};
    assign rem_ge  = rem_sh >= {1'b0, dvsr_q};
    assign rem_sub = rem_sh[31:0] - dvsr_q;

    assign q_fix = qneg_q ? (32'd0 - quot_q) : quot_q;
    assign r_fix = rneg_q ? (32'd0 - rem_q) : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzero_d = dzero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_MTHI: hi_d = req_vs;
                        OP_MTLO: lo_d = req_vs;
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = 6'(MUL_CYCLES - 1);
                            a_d     = req_vs;
                            b_d     = req_vt;
                            sgn_d   = req_signed;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = 6'd32;
                            a_d     = req_vs;
                            quot_d  = (req_signed && req_vs[31]) ? (32'd0 - req_vs) : req_vs;
                            dvsr_d  = (req_signed && req_vt[31]) ? (32'd0 - req_vt) : req_vt;
                            rem_d   = 32'd0;
                            qneg_d  = req_signed && (req_vs[31] ^ req_vt[31]);
                            rneg_d  = req_signed && req_vs[31];
                            dzero_d = (req_vt == 32'd0);
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == 6'd0) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 6'd0) begin
                    // Sign fixup and commit; divide-by-zero overrides the datapath result.
                    if (dzero_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rem_d  = rem_ge ? rem_sub : rem_sh[31:0];
                    quot_d = {quot_q[30:0], rem_ge};
                    cnt_d  = cnt_q - 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dvsr_q  <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzero_q <= dzero_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
